// File: rtl/fish_sprite_render.sv
// Fish sprite compositor for the VGA pixel pipeline.
// Turns the scan position into sprite ROM row/column addresses and waits out the
// ROM's registered read. Opaque texels are drawn over the background colour.
// Sprite moves are held back until the next frame start. A per-frame collision
// flag is also reported.
module fish_sprite_render #(
    parameter int          SCALE_LOG2  = 1,
    parameter logic [9:0]  INIT_X      = 10'd100,
    parameter logic [9:0]  INIT_Y      = 10'd200,
    parameter logic [11:0] TRANSPARENT = 12'h000,
    parameter logic [11:0] HAZARD      = 12'h00F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        bright,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] bg_rgb,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic        pos_valid,
    output logic [2:0]  rom_row,
    output logic [3:0]  rom_col,
    input  logic [11:0] rom_color,
    output logic [11:0] rgb_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_hit
);

    // Sprite box size in screen pixels: 15x8 texels, each scaled up.
    localparam logic [10:0] BOX_W = 11'(15 << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(8 << SCALE_LOG2);

    logic [9:0]  act_x_reg, act_y_reg;
    logic [9:0]  pend_x_reg, pend_y_reg;

    logic        in_box_s1_reg, bright_s1_reg, hsync_s1_reg, vsync_s1_reg;
    logic [11:0] bg_s1_reg;
    logic        in_box_s2_reg, bright_s2_reg, hsync_s2_reg, vsync_s2_reg;
    logic [11:0] bg_s2_reg;
    logic        hit_acc_reg;

    logic [10:0] dx, dy;
    logic        in_box;
    logic        frame_start;
    logic        draw_sprite;
    logic        hit_event;

    // Box test. Bit 10 of each 11-bit difference is the borrow, so a scan position
    // left of or above the sprite is rejected. Coordinates never wrap.
    always_comb begin
        dx          = {1'b0, hc} - {1'b0, act_x_reg};
        dy          = {1'b0, vc} - {1'b0, act_y_reg};
        in_box      = !dx[10] && !dy[10] && (dx < BOX_W) && (dy < BOX_H) && bright;
        frame_start = (hc == 10'd0) && (vc == 10'd0);
        draw_sprite = bright_s2_reg && in_box_s2_reg && (rom_color != TRANSPARENT);
        hit_event   = draw_sprite && (bg_s2_reg == HAZARD);
    end

    // Position registers: strobes go into pend. Pend moves to act only at frame start,
    // so the sprite never tears. On a coincident strobe, act takes the old pend value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_x_reg  <= INIT_X;
            act_y_reg  <= INIT_Y;
            pend_x_reg <= INIT_X;
            pend_y_reg <= INIT_Y;
        end else begin
            if (frame_start) begin
                act_x_reg <= pend_x_reg;
                act_y_reg <= pend_y_reg;
            end
            if (pos_valid) begin
                pend_x_reg <= pos_x;
                pend_y_reg <= pos_y;
            end
        end
    end

    // Stage 1: ROM address generation plus the sideband carried along with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_row       <= 3'd0;
            rom_col       <= 4'd0;
            in_box_s1_reg <= 1'b0;
            bright_s1_reg <= 1'b0;
            hsync_s1_reg  <= 1'b0;
            vsync_s1_reg  <= 1'b0;
            bg_s1_reg     <= 12'd0;
        end else begin
            rom_row       <= in_box ? 3'(dy >> SCALE_LOG2) : 3'd0;
            rom_col       <= in_box ? 4'(dx >> SCALE_LOG2) : 4'd0;
            in_box_s1_reg <= in_box;
            bright_s1_reg <= bright;
            hsync_s1_reg  <= hsync_in;
            vsync_s1_reg  <= vsync_in;
            bg_s1_reg     <= bg_rgb;
        end
    end

    // Stage 2: delay the sideband while the ROM registers its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_box_s2_reg <= 1'b0;
            bright_s2_reg <= 1'b0;
            hsync_s2_reg  <= 1'b0;
            vsync_s2_reg  <= 1'b0;
            bg_s2_reg     <= 12'd0;
        end else begin
            in_box_s2_reg <= in_box_s1_reg;
            bright_s2_reg <= bright_s1_reg;
            hsync_s2_reg  <= hsync_s1_reg;
            vsync_s2_reg  <= vsync_s1_reg;
            bg_s2_reg     <= bg_s1_reg;
        end
    end

    // Output stage: blanking first, then the opaque sprite texel, then the background.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_out   <= 12'd0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            if (!bright_s2_reg)
                rgb_out <= 12'd0;
            else if (draw_sprite)
                rgb_out <= rom_color;
            else
                rgb_out <= bg_s2_reg;
            hsync_out <= hsync_s2_reg;
            vsync_out <= vsync_s2_reg;
        end
    end

    // Collision accumulator. A hit on the frame-start cycle itself still counts
    // toward the frame that is closing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_acc_reg <= 1'b0;
            frame_hit   <= 1'b0;
        end else if (frame_start) begin
            frame_hit   <= hit_acc_reg | hit_event;
            hit_acc_reg <= 1'b0;
        end else if (hit_event) begin
            hit_acc_reg <= 1'b1;
        end
    end

endmodule
